uart0_sout_rx: RTL and testbench
================================

Name: uart0_sout_rx

Overview:
- Receiving end of the SoC's UART0 serial output: deserializes the 8N1 stream on the uart0 sout pad into bytes.
- Used on the board/FPGA side as the host-facing capture block, and in the bench as a synthesizable monitor.
- 16x oversampling with a programmable divider, a 2-flop input synchronizer and a small byte FIFO with a valid/ready pop interface.
- Framing and overflow errors are reported.

Parameters:
- CLK_DIV, 27: i_pad_clk cycles per oversample tick (bit period = 16*CLK_DIV cycles); legal range 2..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, range 2..16.
- LVL_W, 3: width of o_rx_level; must equal log2(FIFO_DEPTH)+1.

Ports:
- i_pad_clk  input  1  single clock for the whole block.
- i_pad_rst_b  input  1  asynchronous reset, active-low.
- i_uart_sin  input  1  serial line, connected to the SoC's o_pad_uart0_sout; asynchronous to i_pad_clk; idle high.
- i_rx_ready  input  1  consumer ready; pops the FIFO head when o_rx_valid is high.
- i_err_clr  input  1  one-cycle pulse; clears o_ovf_err.
- o_rx_valid  output  1  FIFO not empty.
- o_rx_data  output  8  FIFO head byte; valid only while o_rx_valid is high.
- o_rx_level  output  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.
- o_frm_err  output  1  one-cycle pulse on a stop-bit error.
- o_ovf_err  output  1  sticky; a byte was dropped because the FIFO was full.
- o_rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert as seen by the logic):
  - Synchronizer flops reset to 1; FSM goes to IDLE; tick counter, oversample counter (os_cnt) and bit counter go to 0; FIFO is emptied.
  - All outputs reset to 0 (o_rx_data reads 8'h00).
- Tick: a counter runs 0..CLK_DIV-1 continuously; tick is asserted for one cycle when the counter equals CLK_DIV-1. All sampling happens on tick cycles only.
- Synchronizer: two flops; rx_s is the output of the second flop. Sampling latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, and PARITY (present only with the optional feature).
  - IDLE: on a tick with rx_s==0 and armed==1, go to START with os_cnt=0. armed is set by any tick sample of rx_s==1.
  - START: os_cnt increments each tick. At os_cnt==7, sample rx_s:
    - rx_s==1: glitch; return to IDLE, nothing reported.
    - rx_s==0: go to DATA with os_cnt=0 and bit_cnt=0.
  - DATA: at os_cnt==15, sample rx_s into shift register bit[bit_cnt], LSB first, and reset os_cnt to 0. After bit_cnt==7 is sampled, go to STOP (or PARITY).
  - STOP: at os_cnt==15, sample rx_s:
    - rx_s==1: push the byte into the FIFO.
    - rx_s==0: pulse o_frm_err for one cycle, discard the byte, clear armed.
    - Either way go to IDLE. After a framing error a new start is accepted only once the line has been sampled high (break protection).
- Push timing: the byte appears on o_rx_data with o_rx_valid=1 on the cycle after the stop-bit sample tick.
- FIFO:
  - Pop occurs when o_rx_valid && i_rx_ready; o_rx_data is the head combinationally from the registered FIFO.
  - Push while full with no pop in the same cycle: the byte is dropped, o_ovf_err is set, FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, level is unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (valid is still 0 that cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- o_ovf_err clear priority: if i_err_clr and a new overflow occur in the same cycle, the set wins.
- o_rx_busy = (state != IDLE).
- Reset mid-frame: the partial byte is lost, the FIFO is emptied, no error is flagged.

Optional Feature:
- Macro: UART0_RX_PARITY_EN.
- Defined: frame is 8E1. The PARITY state follows DATA and samples at os_cnt==15.
  - On a parity mismatch (XOR of the 8 data bits and the parity bit is nonzero), the byte is discarded and an extra output o_par_err pulses for one cycle on the parity sample cycle; the FSM still proceeds to STOP for the stop-bit check.
  - Parity and framing errors may both pulse for the same frame.
- Undefined: no PARITY state and no o_par_err port; frame is 8N1.

Test Plan (CLK_DIV=4, bit period = 64 cycles):
- Reset release, line idle high for 200 cycles -> o_rx_valid=0, o_rx_level=0, o_rx_busy=0, no error pulses.
- Send 8'hA5 as 8N1 with i_rx_ready=0 -> o_rx_valid rises one cycle after the stop sample tick; o_rx_data=8'hA5; o_rx_level=1. Raise i_rx_ready for 1 cycle -> level=0.
- Low glitch of 20 cycles (shorter than 8 ticks) on an idle line -> returns to IDLE, no byte pushed, no o_frm_err.
- Send 8'h3C with the stop bit forced to 0 -> o_frm_err pulses exactly 1 cycle, level=0. Line held low for 3 bit times then high, followed by 8'h11 -> only 8'h11 is received.
- Send 5 bytes 01..05 with i_rx_ready=0, FIFO_DEPTH=4 -> level=4, o_ovf_err=1, pops return 01,02,03,04. Pulse i_err_clr -> o_ovf_err=0.
- With UART0_RX_PARITY_EN: send 8'h07 with parity bit 1 (correct) -> byte is received. Send 8'h07 with parity bit 0 -> o_par_err pulses, byte is dropped.

Source files
------------

// File: rtl/uart0_sout_rx.sv
// uart0_sout_rx: 16x-oversampled receiver for the SoC UART0 sout pad, feeding a small byte FIFO.
// Define UART0_RX_PARITY_EN to receive 8E1 frames (adds the PARITY state and the o_par_err pulse).
module uart0_sout_rx #(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             i_pad_clk,
  input  logic             i_pad_rst_b,
  input  logic             i_uart_sin,
  input  logic             i_rx_ready,
  input  logic             i_err_clr,
  output logic             o_rx_valid,
  output logic [7:0]       o_rx_data,
  output logic [LVL_W-1:0] o_rx_level,
  output logic             o_frm_err,
  output logic             o_ovf_err,
  output logic             o_rx_busy
`ifdef UART0_RX_PARITY_EN
  ,
  output logic             o_par_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

`ifdef UART0_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [15:0]      r_tick_cnt;
  logic             w_tick;
  logic             r_sync1, r_sync2;
  logic             w_rx_s;
  state_t           r_state, w_state_n;
  logic [3:0]       r_os_cnt, w_os_n;
  logic [2:0]       r_bit_cnt, w_bit_n;
  logic [7:0]       r_shift, w_shift_n;
  logic             r_armed, w_armed_n;
  logic             w_push, w_frm_err, w_par_ok;
`ifdef UART0_RX_PARITY_EN
  logic             r_par_bad, w_par_bad_n, w_par_err;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             w_full, w_pop, w_wr, w_ovf;

  assign w_tick = (r_tick_cnt == 16'(CLK_DIV - 1));
  assign w_rx_s = r_sync2;

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  // Line is idle-high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_sin;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
`ifdef UART0_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_os_cnt  <= w_os_n;
      r_bit_cnt <= w_bit_n;
      r_shift   <= w_shift_n;
      r_armed   <= w_armed_n;
`ifdef UART0_RX_PARITY_EN
      r_par_bad <= w_par_bad_n;
`endif
    end
  end

`ifdef UART0_RX_PARITY_EN
  assign w_par_ok = !r_par_bad;
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_n = r_state;
    w_os_n    = r_os_cnt;
    w_bit_n   = r_bit_cnt;
    w_shift_n = r_shift;
    w_armed_n = r_armed;
    w_push    = 1'b0;
    w_frm_err = 1'b0;
`ifdef UART0_RX_PARITY_EN
    w_par_bad_n = r_par_bad;
    w_par_err   = 1'b0;
`endif
    if (w_tick) begin
      if (w_rx_s) w_armed_n = 1'b1;
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s && r_armed) begin
            w_state_n = START;
            w_os_n    = '0;
          end
        end
        // Mid-start-bit recheck rejects short low glitches.
        START: begin
          if (r_os_cnt == 4'd7) begin
            w_os_n = '0;
            if (w_rx_s) begin
              w_state_n = IDLE;
            end else begin
              w_state_n = DATA;
              w_bit_n   = '0;
            end
          end else begin
            w_os_n = r_os_cnt + 4'd1;
          end
        end
        DATA: begin
          if (r_os_cnt == 4'd15) begin
            w_shift_n[r_bit_cnt] = w_rx_s;
            w_os_n  = '0;
            w_bit_n = r_bit_cnt + 3'd1;
`ifdef UART0_RX_PARITY_EN
            if (r_bit_cnt == 3'd7) w_state_n = PARITY;
`else
            if (r_bit_cnt == 3'd7) w_state_n = STOP;
`endif
          end else begin
            w_os_n = r_os_cnt + 4'd1;
          end
        end
`ifdef UART0_RX_PARITY_EN
        PARITY: begin
          if (r_os_cnt == 4'd15) begin
            w_par_err   = ^{r_shift, w_rx_s};
            w_par_bad_n = w_par_err;
            w_os_n      = '0;
            w_state_n   = STOP;
          end else begin
            w_os_n = r_os_cnt + 4'd1;
          end
        end
`endif
        // A low stop bit disarms start detection until the line is seen high again.
        STOP: begin
          if (r_os_cnt == 4'd15) begin
            w_os_n    = '0;
            w_state_n = IDLE;
            if (w_rx_s) begin
              w_push = w_par_ok;
            end else begin
              w_frm_err = 1'b1;
              w_armed_n = 1'b0;
            end
          end else begin
            w_os_n = r_os_cnt + 4'd1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  assign w_full = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_pop  = o_rx_valid && i_rx_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      o_ovf_err <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop) begin
        r_count <= r_count + LVL_W'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - LVL_W'(1);
      end
      // A fresh overflow outranks a simultaneous clear.
      if (w_ovf) begin
        o_ovf_err <= 1'b1;
      end else if (i_err_clr) begin
        o_ovf_err <= 1'b0;
      end
    end
  end

  assign o_rx_valid = (r_count != '0);
  assign o_rx_data  = o_rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_rx_level = r_count;
  assign o_frm_err  = w_frm_err;
  assign o_rx_busy  = (r_state != IDLE);
`ifdef UART0_RX_PARITY_EN
  assign o_par_err  = w_par_err;
`endif

endmodule

// File: tb/tb_uart0_sout_rx.sv
// tb_uart0_sout_rx: scoreboard bench for uart0_sout_rx at CLK_DIV=4 (64-cycle bit period).
// Expected bytes are queued as frames are sent; a negedge monitor checks every pop.
module tb_uart0_sout_rx;

  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       rstB = 1'b0;
  logic       sin = 1'b1;
  logic       ready = 1'b0;
  logic       errClr = 1'b0;
  logic       rxValid;
  logic [7:0] rxData;
  logic [2:0] rxLevel;
  logic       frmErr;
  logic       ovfErr;
  logic       rxBusy;
`ifdef UART0_RX_PARITY_EN
  logic       parErr;
  int         parCycles = 0;
`endif

  int         compared = 0;
  int         mismatched = 0;
  int         frmCycles = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart0_sout_rx #(.CLK_DIV(4), .FIFO_DEPTH(4), .LVL_W(3)) dut (
    .i_pad_clk   (clk),
    .i_pad_rst_b (rstB),
    .i_uart_sin  (sin),
    .i_rx_ready  (ready),
    .i_err_clr   (errClr),
    .o_rx_valid  (rxValid),
    .o_rx_data   (rxData),
    .o_rx_level  (rxLevel),
    .o_frm_err   (frmErr),
    .o_ovf_err   (ovfErr),
    .o_rx_busy   (rxBusy)
`ifdef UART0_RX_PARITY_EN
    ,
    .o_par_err   (parErr)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReady(input int n);
    ready = 1'b1;
    waitCycles(n);
    ready = 1'b0;
  endtask

  // Sends one frame; checkPush is only meaningful when the FIFO is empty beforehand.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badPar,
                               input logic expectKeep, input logic checkPush);
    bit seen;
    if (expectKeep && stopBit && !badPar) sb.push_back(data);
    sin = 1'b0;
    waitCycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      sin = data[i];
      waitCycles(BIT_CYC);
    end
`ifdef UART0_RX_PARITY_EN
    sin = (^data) ^ badPar;
    waitCycles(BIT_CYC);
`endif
    sin = stopBit;
    seen = 1'b0;
    for (int i = 0; i < BIT_CYC; i++) begin
      waitCycles(1);
      if (!seen && !rxBusy) begin
        seen = 1'b1;
        if (checkPush) begin
          checkOutput("push_valid", 32'(rxValid), 32'd1);
          checkOutput("push_data", 32'(rxData), 32'(data));
        end
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL frame_end: busy still %0d, required 0 by end of stop bit", rxBusy);
    end
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest queued byte.
  always @(negedge clk) begin
    if (rstB) begin
      if (frmErr) frmCycles++;
`ifdef UART0_RX_PARITY_EN
      if (parErr) parCycles++;
`endif
      if (rxValid && ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL pop_unexpected: got %0h, required no byte", rxData);
        end else begin
          checkOutput("pop_data", 32'(rxData), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    waitCycles(5);
    checkOutput("rst_valid", 32'(rxValid), 32'd0);
    checkOutput("rst_data", 32'(rxData), 32'h00);
    checkOutput("rst_level", 32'(rxLevel), 32'd0);
    checkOutput("rst_busy", 32'(rxBusy), 32'd0);
    checkOutput("rst_ovf", 32'(ovfErr), 32'd0);
    rstB = 1'b1;
    waitCycles(200);
    checkOutput("idle_valid", 32'(rxValid), 32'd0);
    checkOutput("idle_level", 32'(rxLevel), 32'd0);
    checkOutput("idle_busy", 32'(rxBusy), 32'd0);
    checkOutput("idle_frm", 32'(frmCycles), 32'd0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("a5_level", 32'(rxLevel), 32'd1);
    checkOutput("a5_data", 32'(rxData), 32'hA5);
    pulseReady(1);
    checkOutput("a5_level_pop", 32'(rxLevel), 32'd0);
    checkOutput("a5_valid_pop", 32'(rxValid), 32'd0);

    sin = 1'b0;
    waitCycles(20);
    checkOutput("glitch_busy", 32'(rxBusy), 32'd1);
    sin = 1'b1;
    waitCycles(200);
    checkOutput("glitch_idle", 32'(rxBusy), 32'd0);
    checkOutput("glitch_level", 32'(rxLevel), 32'd0);
    checkOutput("glitch_frm", 32'(frmCycles), 32'd0);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("frm_pulse", 32'(frmCycles), 32'd1);
    checkOutput("frm_level", 32'(rxLevel), 32'd0);
    sin = 1'b0;
    waitCycles(3 * BIT_CYC);
    checkOutput("break_busy", 32'(rxBusy), 32'd0);
    sin = 1'b1;
    waitCycles(BIT_CYC);
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1, 1'b1);
    pulseReady(1);
    checkOutput("break_frm", 32'(frmCycles), 32'd1);
    checkOutput("break_level", 32'(rxLevel), 32'd0);

    for (int b = 1; b <= 5; b++) begin
      applyStimulus(8'(b), 1'b1, 1'b0, (b <= 4), 1'b0);
    end
    checkOutput("ovf_level", 32'(rxLevel), 32'd4);
    checkOutput("ovf_set", 32'(ovfErr), 32'd1);
    pulseReady(6);
    checkOutput("ovf_drain_level", 32'(rxLevel), 32'd0);
    checkOutput("ovf_sticky", 32'(ovfErr), 32'd1);
    checkOutput("ovf_sb_empty", 32'(sb.size()), 32'd0);
    errClr = 1'b1;
    waitCycles(1);
    errClr = 1'b0;
    checkOutput("ovf_clr", 32'(ovfErr), 32'd0);

`ifdef UART0_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
    pulseReady(1);
    checkOutput("par_good_err", 32'(parCycles), 32'd0);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("par_bad_err", 32'(parCycles), 32'd1);
    checkOutput("par_bad_level", 32'(rxLevel), 32'd0);
    checkOutput("par_bad_frm", 32'(frmCycles), 32'd1);
`endif

    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
    sin = 1'b0;
    waitCycles(3 * BIT_CYC);
    checkOutput("mid_busy", 32'(rxBusy), 32'd1);
    rstB = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(rxBusy), 32'd0);
    checkOutput("mid_rst_level", 32'(rxLevel), 32'd0);
    checkOutput("mid_rst_valid", 32'(rxValid), 32'd0);
    sb.delete();
    sin = 1'b1;
    waitCycles(4);
    rstB = 1'b1;
    waitCycles(200);
    checkOutput("post_rst_busy", 32'(rxBusy), 32'd0);
    checkOutput("post_rst_frm", 32'(frmCycles), 32'd1);
    applyStimulus(8'h96, 1'b1, 1'b0, 1'b1, 1'b1);
    pulseReady(1);
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("final_level", 32'(rxLevel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
